// File: rtl/cc1200_spi_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cc1200_spi_target                                              |
// | Purpose  : SPI target (mode 0) emulating the CC1200 SPI access layer:     |
// |            header decode, 48-byte register file, command strobes, and     |
// |            TX (burst 0x7F write) / RX (burst 0xFF read) byte FIFOs.       |
// | Ports    : clk, rstn (async, active-low)                                  |
// |            sclk, cs_n, mosi in / miso, miso_oe out  - SPI pins            |
// |            tx_pop in / tx_data, tx_count out         - RF side, TX FIFO   |
// |            rx_push, rx_wdata in / rx_count out       - RF side, RX FIFO   |
// |            chip_state, tx_ovf, rx_udf out            - status             |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module cc1200_spi_target #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic               tx_pop,
  output logic [7:0]         tx_data,
  output logic [FIFO_AW:0]   tx_count,
  input  logic               rx_push,
  input  logic [7:0]         rx_wdata,
  output logic [FIFO_AW:0]   rx_count,
  output logic [2:0]         chip_state,
  output logic               tx_ovf,
  output logic               rx_udf
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

  // ---------------- pin synchronizers and edge detect ----------------
  logic [1:0] sclk_s, mosi_s, cs_s;
  logic       sclk_d, cs_d, armed;

  // armed only rises once synchronized cs_n has been seen high, so a
  // transaction already in progress when reset releases is ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_s <= '0; mosi_s <= '0; cs_s <= '0;
      sclk_d <= 1'b0; cs_d <= 1'b0; armed <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk};
      mosi_s <= {mosi_s[0], mosi};
      cs_s   <= {cs_s[0], cs_n};
      sclk_d <= sclk_s[1];
      cs_d   <= cs_s[1];
      if (cs_s[1]) armed <= 1'b1;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[1] & sclk_d;
  assign cs_fall   = armed & cs_d & ~cs_s[1];
  assign cs_rise   = armed & cs_s[1] & ~cs_d;
  assign miso_oe   = armed & ~cs_s[1];

  // ---------------- transaction FSM ----------------
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_IGN} state_t;
  state_t state, state_nx;

  logic [2:0] bit_cnt;
  logic [7:0] sh_in, sh_out, rx_byte, next_byte, status;
  logic       load_pend, rw, burst, byte_end, hdr_done, data_done;
  logic [5:0] addr;

  assign rx_byte  = {sh_in[6:0], mosi_s[1]};
  assign byte_end = sclk_rise & (bit_cnt == 3'd7);
  assign status   = {1'b0, chip_state, 4'b0000};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    hdr_done  = 1'b0;
    data_done = 1'b0;
    if (cs_rise) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nx = ST_HDR;
        ST_HDR: if (byte_end) begin
          hdr_done = 1'b1;
          state_nx = (rx_byte[5:0] <= 6'h2F || rx_byte[5:0] == 6'h3F) ? ST_DATA : ST_IGN;
        end
        ST_DATA: if (byte_end) begin
          data_done = 1'b1;
          if (!burst) state_nx = ST_IGN;
        end
        default: ;
      endcase
    end
  end

  // ---------------- access decode ----------------
  logic is_reg, is_fifo, reg_we, spi_tx_push, spi_rx_pop, strobe, sfrx, sftx;
  assign is_reg      = (addr <= 6'h2F);
  assign is_fifo     = (addr == 6'h3F);
  assign reg_we      = data_done & ~rw & is_reg;
  assign spi_tx_push = data_done & ~rw & is_fifo;
  assign spi_rx_pop  = data_done & rw & is_fifo;
  assign strobe      = hdr_done & (rx_byte[5:0] >= 6'h30) & (rx_byte[5:0] <= 6'h3D);
  assign sfrx        = strobe & (rx_byte[5:0] == 6'h3A);
  assign sftx        = strobe & (rx_byte[5:0] == 6'h3B);

  // ---------------- register file ----------------
  logic [7:0] regs [0:47];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 48; i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[addr] <= rx_byte;
    end
  end

  // ---------------- RX FIFO (RF pushes, SPI pops) ----------------
  logic [7:0]         rx_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] rx_wp, rx_rp;
  logic               rx_full, rx_empty, rx_do_push, rx_do_pop;
  logic [7:0]         rx_head;
  assign rx_full    = (rx_count == CNT_FULL);
  assign rx_empty   = (rx_count == '0);
  assign rx_do_push = rx_push & ~rx_full & ~sfrx;
  assign rx_do_pop  = spi_rx_pop & ~rx_empty;
  assign rx_head    = rx_empty ? 8'h00 : rx_mem[rx_rp];

  always_ff @(posedge clk) if (rx_do_push) rx_mem[rx_wp] <= rx_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0; rx_udf <= 1'b0;
    end else if (sfrx) begin
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0; rx_udf <= 1'b0;
    end else begin
      if (rx_do_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_do_pop)  rx_rp <= rx_rp + PTR_ONE;
      if (spi_rx_pop && rx_empty) rx_udf <= 1'b1;
      case ({rx_do_push, rx_do_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // ---------------- TX FIFO (SPI pushes, RF pops) ----------------
  logic [7:0]         tx_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] tx_wp, tx_rp;
  logic               tx_full, tx_empty, tx_do_push, tx_do_pop;
  assign tx_full    = (tx_count == CNT_FULL);
  assign tx_empty   = (tx_count == '0);
  assign tx_do_push = spi_tx_push & ~tx_full;
  assign tx_do_pop  = tx_pop & ~tx_empty & ~sftx;
  assign tx_data    = tx_empty ? 8'h00 : tx_mem[tx_rp];

  always_ff @(posedge clk) if (tx_do_push) tx_mem[tx_wp] <= rx_byte;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0; tx_ovf <= 1'b0;
    end else if (sftx) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0; tx_ovf <= 1'b0;
    end else begin
      if (tx_do_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_do_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (spi_tx_push && tx_full) tx_ovf <= 1'b1;
      case ({tx_do_push, tx_do_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // ---------------- chip state (strobes) ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chip_state <= 3'b000;
    end else if (strobe) begin
      case (rx_byte[5:0])
        6'h34:   chip_state <= 3'b001;
        6'h35:   chip_state <= 3'b010;
        6'h36:   chip_state <= 3'b000;
        default: ;
      endcase
    end
  end

  // ---------------- shift registers ----------------
  // Byte loaded onto MISO at the fall after a byte completes. The RX head is
  // read after the previous byte's pop has committed, so it is already fresh.
  always_comb begin
    next_byte = 8'h00;
    if (state == ST_DATA) begin
      if (!rw)          next_byte = status;
      else if (is_fifo) next_byte = rx_head;
      else              next_byte = regs[addr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= 3'd0; sh_in <= 8'h00; sh_out <= 8'h00; load_pend <= 1'b0;
      rw <= 1'b0; burst <= 1'b0; addr <= 6'h00;
    end else begin
      if (cs_fall) begin
        bit_cnt <= 3'd0; sh_in <= 8'h00; load_pend <= 1'b0;
        sh_out  <= status;
      end else if (cs_rise) begin
        sh_out <= 8'h00; load_pend <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (sclk_rise) begin
          sh_in   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) load_pend <= 1'b1;
        end
        if (sclk_fall) begin
          if (load_pend) begin
            sh_out    <= next_byte;
            load_pend <= 1'b0;
          end else begin
            sh_out <= {sh_out[6:0], 1'b0};
          end
        end
      end
      if (hdr_done) begin
        rw <= rx_byte[7]; burst <= rx_byte[6]; addr <= rx_byte[5:0];
      end else if (data_done && is_reg) begin
        addr <= (addr == 6'h2F) ? 6'h00 : addr + 6'd1;
      end
    end
  end

  assign miso = sh_out[7];

endmodule
`default_nettype wire

// File: tb/tb_cc1200_spi_target.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cc1200_spi_target                                           |
// | Purpose  : directed self-checking bench for cc1200_spi_target; acts as    |
// |            the SPI master (mode 0) and the RF-side FIFO user.             |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cc1200_spi_target;
  localparam int HALF = 80;  // SCLK half period, 16 clk per SCLK period

  logic       clk = 1'b0, rstn = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       tx_pop = 1'b0, rx_push = 1'b0;
  logic [7:0] rx_wdata = 8'h00;
  logic       miso, miso_oe, tx_ovf, rx_udf;
  logic [7:0] tx_data;
  logic [4:0] tx_count, rx_count;
  logic [2:0] chip_state;

  cc1200_spi_target #(.FIFO_AW(4)) dut (
    .clk(clk), .rstn(rstn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_pop(tx_pop), .tx_data(tx_data),
    .tx_count(tx_count), .rx_push(rx_push), .rx_wdata(rx_wdata),
    .rx_count(rx_count), .chip_state(chip_state), .tx_ovf(tx_ovf), .rx_udf(rx_udf)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] txb [0:19];
  logic [7:0] rxb [0:19];
  logic [7:0] scratch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shift nb bits of b out MSB first; miso sampled just before each rise.
  task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = b[7-i];
      #HALF;
      r = {r[6:0], miso};
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input int n);
    cs_n = 1'b0;
    for (int k = 0; k < n; k++) spi_bits(txb[k], 8, rxb[k]);
    #HALF;
    cs_n = 1'b1;
    #(2*HALF);
  endtask

  task automatic rf_pop();
    tx_pop = 1'b1; #10; tx_pop = 1'b0; #10;
  endtask

  task automatic rf_push(input logic [7:0] d);
    rx_wdata = d; rx_push = 1'b1; #10; rx_push = 1'b0; #10;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_miso_oe"}, miso_oe, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_count"}, tx_count, 0);
    chk({tag, "_rx_count"}, rx_count, 0);
    chk({tag, "_chip_state"}, chip_state, 0);
    chk({tag, "_tx_ovf"}, tx_ovf, 0);
    chk({tag, "_rx_udf"}, rx_udf, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    rstn = 1'b0; #40;
    chk_reset("rst");
    rstn = 1'b1; #40;

    // single write 0x05 = 0xA5, then single read with trailing bytes
    txb[0] = 8'h05; txb[1] = 8'hA5; xfer(2);
    chk("wr05_status", rxb[0], 8'h00);
    txb[0] = 8'h85; txb[1] = 8'h00; txb[2] = 8'h00; txb[3] = 8'h00; xfer(4);
    chk("rd05_status", rxb[0], 8'h00);
    chk("rd05_data", rxb[1], 8'hA5);
    chk("rd05_extra1", rxb[2], 8'h00);
    chk("rd05_extra2", rxb[3], 8'h00);

    // burst write across the 0x2F -> 0x00 wrap, then burst read back
    txb[0] = 8'h6E; txb[1] = 8'h11; txb[2] = 8'h22; txb[3] = 8'h33; xfer(4);
    txb[0] = 8'hEE; txb[1] = 8'h00; txb[2] = 8'h00; txb[3] = 8'h00; xfer(4);
    chk("brd_2e", rxb[1], 8'h11);
    chk("brd_2f", rxb[2], 8'h22);
    chk("brd_00", rxb[3], 8'h33);

    // strobes
    txb[0] = 8'h35; xfer(1);
    chk("stx_state", chip_state, 3'b010);
    txb[0] = 8'h80; txb[1] = 8'h00; xfer(2);
    chk("stx_status", rxb[0], 8'h20);
    chk("rd00_data", rxb[1], 8'h33);
    txb[0] = 8'h34; xfer(1);
    chk("srx_old_status", rxb[0], 8'h20);
    txb[0] = 8'h80; txb[1] = 8'h00; xfer(2);
    chk("srx_status", rxb[0], 8'h10);
    txb[0] = 8'h36; xfer(1);
    chk("sidle_old_status", rxb[0], 8'h10);
    chk("sidle_state", chip_state, 3'b000);

    // TX FIFO overflow and drain
    txb[0] = 8'h7F;
    for (int i = 1; i <= 17; i++) txb[i] = 8'(i);
    xfer(18);
    chk("tx_full_count", tx_count, 16);
    chk("tx_ovf_set", tx_ovf, 1);
    for (int i = 1; i <= 16; i++) begin
      chk("tx_pop_data", tx_data, i);
      rf_pop();
    end
    chk("tx_drained_count", tx_count, 0);
    chk("tx_drained_data", tx_data, 0);
    rf_pop();
    chk("tx_pop_empty_count", tx_count, 0);
    txb[0] = 8'h7F; txb[1] = 8'hAA; txb[2] = 8'hBB; xfer(3);
    chk("tx_refill_count", tx_count, 2);
    chk("tx_ovf_sticky", tx_ovf, 1);
    chk("tx_refill_head", tx_data, 8'hAA);
    txb[0] = 8'h3B; xfer(1);
    chk("sftx_count", tx_count, 0);
    chk("sftx_ovf", tx_ovf, 0);

    // RX FIFO read with underflow
    rf_push(8'hC1); rf_push(8'hC2);
    chk("rx_count2", rx_count, 2);
    txb[0] = 8'hFF; txb[1] = 8'h00; txb[2] = 8'h00; txb[3] = 8'h00; xfer(4);
    chk("rx_rd0", rxb[1], 8'hC1);
    chk("rx_rd1", rxb[2], 8'hC2);
    chk("rx_rd2", rxb[3], 8'h00);
    chk("rx_after_count", rx_count, 0);
    chk("rx_udf_set", rx_udf, 1);
    txb[0] = 8'h3A; xfer(1);
    chk("sfrx_udf", rx_udf, 0);
    rf_push(8'hD1); rf_push(8'hD2); rf_push(8'hD3);
    txb[0] = 8'hFF; txb[1] = 8'h00; txb[2] = 8'h00; xfer(3);
    chk("rx2_rd0", rxb[1], 8'hD1);
    chk("rx2_rd1", rxb[2], 8'hD2);
    chk("rx2_count", rx_count, 1);
    chk("rx2_udf", rx_udf, 0);
    for (int i = 0; i < 16; i++) rf_push(8'(8'hE0 + i));
    chk("rx_full_count", rx_count, 16);
    txb[0] = 8'h3A; xfer(1);
    chk("sfrx_count", rx_count, 0);

    // cs_n raised mid data byte: no write
    txb[0] = 8'h10; txb[1] = 8'h5A; xfer(2);
    cs_n = 1'b0;
    spi_bits(8'h10, 8, scratch);
    chk("oe_active", miso_oe, 1);
    spi_bits(8'hFF, 5, scratch);
    #HALF; cs_n = 1'b1; #(2*HALF);
    chk("oe_idle", miso_oe, 0);
    txb[0] = 8'h90; txb[1] = 8'h00; xfer(2);
    chk("partial_reg10", rxb[1], 8'h5A);

    // reset in the middle of a burst with state set up beforehand
    txb[0] = 8'h35; xfer(1);
    rf_push(8'hE1);
    cs_n = 1'b0;
    spi_bits(8'h7F, 8, scratch);
    spi_bits(8'h01, 8, scratch);
    spi_bits(8'h02, 4, scratch);
    rstn = 1'b0; #40;
    chk_reset("midrst");
    rstn = 1'b1; #40;
    // cs_n still low: these bytes must be ignored
    spi_bits(8'h01, 8, scratch);
    spi_bits(8'h77, 8, scratch);
    chk("post_rst_oe", miso_oe, 0);
    #HALF; cs_n = 1'b1; #(2*HALF);
    txb[0] = 8'h81; txb[1] = 8'h00; xfer(2);
    chk("post_rst_reg01", rxb[1], 8'h00);
    txb[0] = 8'h85; txb[1] = 8'h00; xfer(2);
    chk("post_rst_reg05", rxb[1], 8'h00);
    chk("post_rst_tx_count", tx_count, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
